// File: rtl/game_round_sequencer_pkg.sv
// Shared definitions for the round sequencer: FSM states, house codes and
// the IR sensor array width.
package game_round_sequencer_pkg;

  localparam int unsigned IR_W = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_PLAY,
    ST_SHOWUP,
    ST_BOARD
  } state_t;

  typedef enum logic [1:0] {
    HOUSE_G = 2'b00,
    HOUSE_S = 2'b01,
    HOUSE_H = 2'b10,
    HOUSE_R = 2'b11
  } house_t;

endpackage

// File: rtl/game_round_sequencer_tick_divider.sv
// One-second tick generator: free-running modulo counter with a synchronous
// clear, pulsing tick during the last count of each period.
module tick_divider #(
  parameter int unsigned CLKS_PER_TICK = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == CNT_W'(CLKS_PER_TICK - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr || tick) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/game_round_sequencer.sv
// Round flow controller: get-ready countdown, timed play, times-up banner and
// leaderboard, plus per-house hit scoring from the synchronised IR sensors.
module game_round_sequencer
  import game_round_sequencer_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 50000000,
  parameter int unsigned READY_SECS    = 3,
  parameter int unsigned PLAY_SECS     = 60,
  parameter int unsigned SHOW_SECS     = 5,
  parameter int unsigned SCORE_W       = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         house_sel,
  input  logic [24:0]        ir_in,
  output logic               G,
  output logic               S,
  output logic               H,
  output logic               R,
  output logic               get_ready,
  output logic               times_up,
  output logic               leaderboard,
  output logic [6:0]         seconds_left,
  output logic [SCORE_W-1:0] score_g,
  output logic [SCORE_W-1:0] score_s,
  output logic [SCORE_W-1:0] score_h,
  output logic [SCORE_W-1:0] score_r
);

  localparam logic [SCORE_W+4:0] SCORE_MAX = {5'b0, {SCORE_W{1'b1}}};

  state_t            state_q, state_d;
  house_t            house_q, house_d;
  logic [6:0]        sec_q, sec_d;
  logic [3:0]        flags_q, flags_d;
  logic              get_ready_q, get_ready_d;
  logic              times_up_q, times_up_d;
  logic              leaderboard_q, leaderboard_d;
  logic              tick, tick_clr;

  logic [IR_W-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d, rise;
  logic [4:0]        hits;
  logic [SCORE_W+4:0] sum;
  logic [SCORE_W-1:0] score_q [4];
  logic [SCORE_W-1:0] score_d [4];

  tick_divider #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick (
    .clk (CLOCK_50),
    .rst (reset),
    .clr (tick_clr),
    .tick(tick)
  );

  // Outputs are derived from the next state so they switch on the same
  // edge as the state register.
  always_comb begin
    state_d = state_q;
    house_d = house_q;
    sec_d   = sec_q;
    if (abort) begin
      state_d = ST_IDLE;
      sec_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_BOARD: begin
          if (start) begin
            state_d = ST_READY;
            house_d = house_t'(house_sel);
            sec_d   = 7'(READY_SECS);
          end
        end
        ST_READY: begin
          if (tick) begin
            if (sec_q <= 7'd1) begin
              state_d = ST_PLAY;
              sec_d   = 7'(PLAY_SECS);
            end else begin
              sec_d = sec_q - 7'd1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (sec_q <= 7'd1) begin
              state_d = ST_SHOWUP;
              sec_d   = 7'(SHOW_SECS);
            end else begin
              sec_d = sec_q - 7'd1;
            end
          end
        end
        ST_SHOWUP: begin
          if (tick) begin
            if (sec_q <= 7'd1) begin
              state_d = ST_BOARD;
              sec_d   = '0;
            end else begin
              sec_d = sec_q - 7'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          sec_d   = '0;
        end
      endcase
    end

    tick_clr      = (state_d != state_q);
    get_ready_d   = (state_d == ST_READY);
    times_up_d    = (state_d == ST_SHOWUP);
    leaderboard_d = (state_d == ST_BOARD);
    flags_d       = '0;
    if (state_d == ST_READY || state_d == ST_PLAY || state_d == ST_SHOWUP)
      flags_d[house_d] = 1'b1;
  end

  always_comb begin
    sync1_d = ir_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    rise    = sync2_q & ~hist_q;
    hits    = '0;
    for (int unsigned i = 0; i < IR_W; i++) hits = hits + 5'(rise[i]);
    sum     = {5'b0, score_q[house_q]} + (SCORE_W + 5)'(hits);
    score_d = score_q;
    if (state_q == ST_PLAY)
      score_d[house_q] = (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      house_q       <= HOUSE_G;
      sec_q         <= '0;
      flags_q       <= '0;
      get_ready_q   <= 1'b0;
      times_up_q    <= 1'b0;
      leaderboard_q <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      hist_q        <= '0;
      score_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      house_q       <= house_d;
      sec_q         <= sec_d;
      flags_q       <= flags_d;
      get_ready_q   <= get_ready_d;
      times_up_q    <= times_up_d;
      leaderboard_q <= leaderboard_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      score_q       <= score_d;
    end
  end

  assign G            = flags_q[HOUSE_G];
  assign S            = flags_q[HOUSE_S];
  assign H            = flags_q[HOUSE_H];
  assign R            = flags_q[HOUSE_R];
  assign get_ready    = get_ready_q;
  assign times_up     = times_up_q;
  assign leaderboard  = leaderboard_q;
  assign seconds_left = sec_q;
  assign score_g      = score_q[HOUSE_G];
  assign score_s      = score_q[HOUSE_S];
  assign score_h      = score_q[HOUSE_H];
  assign score_r      = score_q[HOUSE_R];

endmodule
